branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-bit Branch/Zero gating in the EX stage of the 5-stage pipeline.
- AND-gates each of NUM_COND branch-type enables against its condition flag and OR-reduces the results into a taken decision.
- Registers the decision and the target address toward the PC mux.
- Sequences a multi-cycle flush of wrong-path instructions in IF/ID through a small FSM.

Parameters:
- ADDR_WIDTH, 32, width of branch target and BranchAddr.
- NUM_COND, 4, number of condition channels (index 0 EQ, 1 NE, 2 LEZ, 3 GTZ); must be ≥1.
- FLUSH_CYCLES, 2, cycles Flush stays high after a taken branch; must be ≥1.

Ports:
- Clk, input, 1, single clock, rising edge.
- Reset, input, 1, synchronous, active-high.
- Stall, input, 1, hazard stall; holds all state.
- Valid, input, 1, EX-stage instruction valid.
- BranchType, input, NUM_COND, per-channel branch enable from control; may be multi-hot.
- Cond, input, NUM_COND, per-channel condition flag from the ALU (Zero, !Zero, ...).
- Target, input, ADDR_WIDTH, computed branch target.
- PCSrc, output, 1, registered taken pulse to the PC mux.
- BranchAddr, output, ADDR_WIDTH, registered target, valid while PCSrc=1.
- Flush, output, 1, registered IF/ID flush.
- Busy, output, 1, high while in state FLUSH.

Behaviour:
- Clk is the only clock. Reset is synchronous and active-high, sampled on the rising edge of Clk.
- Reset sets: PCSrc=0, BranchAddr=0, Flush=0, Busy=0, state=IDLE, flush counter=0.
- Reset has priority over Stall and all other inputs. A reset mid-flush aborts the flush immediately.
- taken = Valid & |(BranchType & Cond). Multi-hot BranchType: any matching channel gives taken.
- Stall=1: every register holds its value (PCSrc, BranchAddr, Flush, state, counter). Inputs are ignored.
- FSM state IDLE:
  - taken on a non-stalled edge → next cycle PCSrc=1, BranchAddr=Target, Flush=1, Busy=1, counter=FLUSH_CYCLES-1, go to FLUSH.
  - Otherwise PCSrc=0 and Flush=0. BranchAddr holds its last value.
- FSM state FLUSH:
  - PCSrc drops to 0 after exactly one non-stalled cycle.
  - If counter==0 → Flush=0, Busy=0, go to IDLE. Otherwise counter decrements and Flush stays 1.
  - Valid/taken inputs are ignored, because those instructions are in the branch shadow.
- Latency: 1 cycle from the taken evaluation to PCSrc.
- Flush is high for exactly FLUSH_CYCLES non-stalled cycles, beginning in the same cycle as PCSrc.
- FLUSH_CYCLES=1: FLUSH lasts one cycle. A branch resolved on the edge that returns the FSM to IDLE is ignored; one arriving the following cycle is accepted.
- Counter width is $clog2(FLUSH_CYCLES+1).
- Target is captured unmodified. No arithmetic is applied.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds output ports ResolvedCount[31:0] and TakenCount[31:0].
  - ResolvedCount increments on every accepted non-stalled edge with Valid & |BranchType in IDLE.
  - TakenCount increments when that resolution is also taken.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package/header holds:
  - state localparams S_IDLE=1'b0, S_FLUSH=1'b1;
  - condition indices COND_EQ=0, COND_NE=1, COND_LEZ=2, COND_GTZ=3.
- One sub-module is natural: flush_counter (load, decrement, hold-on-stall, zero flag), parametrised by FLUSH_CYCLES.

Test Plan:
- Reset then Valid=1, BranchType=4'b0001, Cond=4'b0001, Target=32'h0000_0040 → next cycle PCSrc=1, BranchAddr=32'h40, Flush=1. PCSrc=0 one cycle later. Flush=0 after 2 cycles total.
- BranchType=4'b0010, Cond=4'b0001 (BNE with Zero set) → PCSrc stays 0, Flush stays 0, Busy stays 0.
- Taken branch, then Stall=1 for 3 cycles in the PCSrc cycle → PCSrc, Flush and BranchAddr hold for 3 cycles. Flush then lasts 2 more non-stalled cycles with PCSrc=1 for the first of them only.
- Second taken branch during FLUSH (Target=32'h80) → ignored: BranchAddr stays 32'h40, no extra PCSrc pulse. A taken branch one cycle after Busy=0 is accepted.
- Reset asserted in the first Flush cycle → next cycle all outputs 0, Busy=0. A following taken branch behaves as in the first scenario.
- With BRANCH_STATS_EN: 5 resolved branches, 3 of them taken → ResolvedCount=5, TakenCount=3.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the EX-stage branch resolve unit.
package branch_resolve_unit_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam int COND_EQ  = 0;
    localparam int COND_NE  = 1;
    localparam int COND_LEZ = 2;
    localparam int COND_GTZ = 3;

    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_flush_counter.sv
// Flush length counter: loads FLUSH_CYCLES-1, counts down to zero, freezes on stall.
module branch_resolve_unit_flush_counter #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Stall,
    input  logic Load,
    input  logic Decrement,
    output logic Zero
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VALUE = CW'(FLUSH_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (!Stall) begin
            if (Load) begin
                count <= LOAD_VALUE;
            end else if (Decrement && (count != '0)) begin
                count <= count - CW'(1);
            end
        end
    end

    assign Zero = (count == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: gates branch enables against condition flags, drives the
// PC mux and sequences the IF/ID flush. Optional statistics counters: BRANCH_STATS_EN.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_COND     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Valid,
    input  logic [NUM_COND-1:0]   BranchType,
    input  logic [NUM_COND-1:0]   Cond,
    input  logic [ADDR_WIDTH-1:0] Target,
    output logic                  PCSrc,
    output logic [ADDR_WIDTH-1:0] BranchAddr,
    output logic                  Flush,
    output logic                  Busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           ResolvedCount,
    output logic [31:0]           TakenCount
`endif
);

    state_t state;
    state_t nextState;
    logic   taken;
    logic   acceptBranch;
    logic   counterZero;

    assign taken        = Valid & (|(BranchType & Cond));
    assign acceptBranch = (state == S_IDLE) && taken;

    branch_resolve_unit_flush_counter #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) flushCounter (
        .Clk       (Clk),
        .Reset     (Reset),
        .Stall     (Stall),
        .Load      (acceptBranch),
        .Decrement (state == S_FLUSH),
        .Zero      (counterZero)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else if (!Stall) begin
            state <= nextState;
        end
    end

    // Instructions arriving while flushing sit in the branch shadow, so FLUSH never looks at taken.
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (taken)       nextState = S_FLUSH;
            S_FLUSH: if (counterZero) nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state == S_FLUSH);
        Flush = (state == S_FLUSH);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PCSrc      <= 1'b0;
            BranchAddr <= '0;
        end else if (!Stall) begin
            PCSrc <= acceptBranch;
            if (acceptBranch) begin
                BranchAddr <= Target;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic resolveEvent;

    assign resolveEvent = !Stall && (state == S_IDLE) && Valid && (|BranchType);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ResolvedCount <= '0;
            TakenCount    <= '0;
        end else if (resolveEvent) begin
            ResolvedCount <= satInc(ResolvedCount);
            if (taken) begin
                TakenCount <= satInc(TakenCount);
            end
        end
    end
`else
    // Default build carries no statistics hardware.
`endif

endmodule
